// File: rtl/aes_block_packer.sv
// Packs a byte stream into 128-bit blocks; the first block after reset is the key block.
// Latency: ready pulses the cycle after the 16th byte edge, provided no block is pending.
// Backpressure: byte_ready drops while a complete block waits for the output register.
module aes_block_packer #(
  parameter int unsigned KEY_HOLD = 2
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         byte_valid,
  input  logic [7:0]   byte_data,
  output logic         byte_ready,
  input  logic         abort,
  input  logic         complete,
  output logic         ready,
  output logic [0:127] data_out,
  output logic         is_key,
  output logic [15:0]  blocks_sent,
  output logic         proto_err
);

  logic [0:127] asm_q, asm_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         asm_full_q, asm_full_d;
  logic [0:127] dout_q, dout_d;
  logic         pending_q, pending_d;
  logic         ready_q, ready_d;
  logic         is_key_q, is_key_d;
  logic         key_phase_q, key_phase_d;
  logic [15:0]  sent_q, sent_d;
  logic         perr_q, perr_d;
  logic [3:0]   hold_q, hold_d;

  logic accept;
  logic last_byte;
  logic xfer;
  logic key_tick;
  logic key_release;
  logic data_release;

  // Next-state logic for assembly, output register, key hold and error flag
  always_comb begin
    accept       = byte_valid && !asm_full_q;
    last_byte    = accept && (cnt_q == 4'd15);
    // abort beats a transfer on the same edge
    xfer         = (asm_full_q || last_byte) && !pending_q && !abort;
    // the hold counter only starts running once the ready cycle has passed
    key_tick     = pending_q && is_key_q && !ready_q;
    key_release  = key_tick && (hold_q == 4'd1);
    data_release = complete && pending_q && !is_key_q && !ready_q;

    asm_d = asm_q;
    if (accept) begin
      asm_d[{cnt_q, 3'b000} +: 8] = byte_data;
    end

    cnt_d = cnt_q;
    if (abort) begin
      cnt_d = 4'd0;
    end else if (accept) begin
      cnt_d = cnt_q + 4'd1;
    end

    asm_full_d = asm_full_q;
    if (abort || xfer) begin
      asm_full_d = 1'b0;
    end else if (last_byte) begin
      asm_full_d = 1'b1;
    end

    // asm_d already contains the byte landing on this edge
    dout_d      = xfer ? asm_d : dout_q;
    is_key_d    = xfer ? key_phase_q : is_key_q;
    key_phase_d = xfer ? 1'b0 : key_phase_q;
    sent_d      = xfer ? sent_q + 16'd1 : sent_q;
    ready_d     = xfer;

    pending_d = pending_q;
    if (xfer) begin
      pending_d = 1'b1;
    end else if (key_release || data_release) begin
      pending_d = 1'b0;
    end

    hold_d = hold_q;
    if (xfer) begin
      hold_d = 4'(KEY_HOLD);
    end else if (key_tick && (hold_q != 4'd0)) begin
      hold_d = hold_q - 4'd1;
    end

    perr_d = perr_q || (complete && (!pending_q || is_key_q));
  end

  // State registers; reset drops partial bytes and any pending block
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      asm_q       <= '0;
      cnt_q       <= 4'd0;
      asm_full_q  <= 1'b0;
      dout_q      <= '0;
      pending_q   <= 1'b0;
      ready_q     <= 1'b0;
      is_key_q    <= 1'b0;
      key_phase_q <= 1'b1;
      sent_q      <= 16'd0;
      perr_q      <= 1'b0;
      hold_q      <= 4'd0;
    end else begin
      asm_q       <= asm_d;
      cnt_q       <= cnt_d;
      asm_full_q  <= asm_full_d;
      dout_q      <= dout_d;
      pending_q   <= pending_d;
      ready_q     <= ready_d;
      is_key_q    <= is_key_d;
      key_phase_q <= key_phase_d;
      sent_q      <= sent_d;
      perr_q      <= perr_d;
      hold_q      <= hold_d;
    end
  end

  assign byte_ready  = !asm_full_q;
  assign ready       = ready_q;
  assign data_out    = dout_q;
  assign is_key      = is_key_q;
  assign blocks_sent = sent_q;
  assign proto_err   = perr_q;

endmodule

// File: tb/tb_aes_block_packer.sv
// Bench for aes_block_packer: queue-based block model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_aes_block_packer;

  localparam int KH = 2;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         byte_valid = 1'b0;
  logic [7:0]   byte_data = 8'h00;
  logic         abort = 1'b0;
  logic         complete = 1'b0;
  logic         byte_ready;
  logic         ready;
  logic [0:127] data_out;
  logic         is_key;
  logic [15:0]  blocks_sent;
  logic         proto_err;

  int n_chk = 0;
  int n_err = 0;

  aes_block_packer #(.KEY_HOLD(KH)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .abort      (abort),
    .complete   (complete),
    .ready      (ready),
    .data_out   (data_out),
    .is_key     (is_key),
    .blocks_sent(blocks_sent),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]   m_q[$];
  logic [0:127] m_blk = '0;
  bit           m_pend = 0;
  bit           m_key = 0;
  bit           m_kphase = 1;
  bit           m_ready = 0;
  bit           m_err = 0;
  int           m_left = 0;
  logic [15:0]  m_sent = 16'd0;

  initial begin : model
    bit acc;
    bit xfer;
    bit rel;
    forever begin
      @(posedge clk or negedge n_rst);
      if (!n_rst) begin
        m_q.delete();
        m_blk = '0; m_pend = 0; m_key = 0; m_kphase = 1;
        m_ready = 0; m_err = 0; m_left = 0; m_sent = 16'd0;
      end else begin
        acc  = byte_valid && (m_q.size() < 16);
        rel  = 0;
        xfer = 0;
        if (complete && (!m_pend || m_key)) m_err = 1;
        if (m_pend && !m_key && complete && !m_ready) rel = 1;
        if (m_pend && m_key) begin
          m_left--;
          if (m_left == 0) rel = 1;
        end
        if (abort) begin
          m_q.delete();
        end else begin
          if (acc) m_q.push_back(byte_data);
          if (m_q.size() == 16 && !m_pend) begin
            xfer = 1;
            for (int i = 0; i < 16; i++) m_blk[8*i +: 8] = m_q[i];
            m_q.delete();
            m_key = m_kphase;
            m_kphase = 0;
            m_sent = m_sent + 16'd1;
            m_pend = 1;
            // key stays pending through the ready cycle plus KH more cycles
            m_left = KH + 1;
          end
        end
        if (rel) m_pend = 0;
        m_ready = xfer;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    forever begin
      @(negedge clk);
      chk("cyc_ready", {127'd0, ready}, {127'd0, m_ready});
      chk("cyc_byte_ready", {127'd0, byte_ready}, {127'd0, (m_q.size() < 16)});
      chk("cyc_data_out", data_out, m_blk);
      chk("cyc_is_key", {127'd0, is_key}, {127'd0, m_key});
      chk("cyc_blocks_sent", {112'd0, blocks_sent}, {112'd0, m_sent});
      chk("cyc_proto_err", {127'd0, proto_err}, {127'd0, m_err});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && w < 50) begin
      tick();
      w++;
    end
    if (!byte_ready) begin
      n_chk++;
      n_err++;
      $display("FAIL send_byte_timeout: byte_ready=%0b required 1", byte_ready);
    end
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, {127'd0, ready}, 128'd0);
    chk({tag, "_data_out"}, data_out, 128'd0);
    chk({tag, "_is_key"}, {127'd0, is_key}, 128'd0);
    chk({tag, "_blocks_sent"}, {112'd0, blocks_sent}, 128'd0);
    chk({tag, "_proto_err"}, {127'd0, proto_err}, 128'd0);
    chk({tag, "_byte_ready"}, {127'd0, byte_ready}, 128'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin : main
    repeat (2) tick();
    n_rst = 1'b1;
    chk_reset_vals("rst0");

    // key block 0x00..0x0F
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    chk("key_ready", {127'd0, ready}, 128'd1);
    chk("key_data", data_out, 128'h000102030405060708090a0b0c0d0e0f);
    chk("key_is_key", {127'd0, is_key}, 128'd1);
    chk("key_sent", {112'd0, blocks_sent}, 128'd1);
    tick();
    chk("key_ready_drop", {127'd0, ready}, 128'd0);

    // data block 0x10..0x1F, complete one cycle after ready
    for (int i = 16; i < 32; i++) send_byte(8'(i));
    chk("d1_ready", {127'd0, ready}, 128'd1);
    chk("d1_data", data_out, 128'h101112131415161718191a1b1c1d1e1f);
    chk("d1_is_key", {127'd0, is_key}, 128'd0);
    chk("d1_sent", {112'd0, blocks_sent}, 128'd2);
    tick();
    complete = 1'b1;
    tick();
    complete = 1'b0;
    chk("d1_proto_err", {127'd0, proto_err}, 128'd0);

    // backpressure: 32 bytes with no complete
    for (int i = 32'h20; i < 32'h40; i++) send_byte(8'(i));
    chk("bp_byte_ready_low", {127'd0, byte_ready}, 128'd0);
    chk("bp_sent", {112'd0, blocks_sent}, 128'd3);
    chk("bp_data_held", data_out, 128'h202122232425262728292a2b2c2d2e2f);
    byte_valid = 1'b1;
    byte_data  = 8'h40;
    repeat (3) tick();
    chk("bp_stall", {127'd0, byte_ready}, 128'd0);
    chk("bp_sent_stall", {112'd0, blocks_sent}, 128'd3);
    complete = 1'b1;
    tick();
    complete = 1'b0;
    chk("bp_release_no_ready", {127'd0, ready}, 128'd0);
    tick();
    chk("bp_ready", {127'd0, ready}, 128'd1);
    chk("bp_data2", data_out, 128'h303132333435363738393a3b3c3d3e3f);
    chk("bp_sent2", {112'd0, blocks_sent}, 128'd4);
    chk("bp_byte_ready_back", {127'd0, byte_ready}, 128'd1);
    tick();
    byte_valid = 1'b0;
    complete = 1'b1;
    tick();
    complete = 1'b0;

    // abort alongside a byte, then a clean block
    for (int i = 32'h50; i < 32'h57; i++) send_byte(8'(i));
    byte_valid = 1'b1;
    byte_data  = 8'h57;
    abort      = 1'b1;
    tick();
    abort      = 1'b0;
    byte_valid = 1'b0;
    for (int i = 32'hA0; i < 32'hB0; i++) send_byte(8'(i));
    chk("ab_ready", {127'd0, ready}, 128'd1);
    chk("ab_data", data_out, 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf);
    chk("ab_sent", {112'd0, blocks_sent}, 128'd5);
    tick();
    complete = 1'b1;
    tick();
    complete = 1'b0;

    // reset with a pending data block and 10 partial bytes
    for (int i = 32'hB0; i < 32'hC0; i++) send_byte(8'(i));
    for (int i = 32'hC0; i < 32'hCA; i++) send_byte(8'(i));
    n_rst = 1'b0;
    #1;
    chk_reset_vals("rst1");
    tick();
    n_rst = 1'b1;
    for (int i = 32'hD0; i < 32'hE0; i++) send_byte(8'(i));
    chk("rk_ready", {127'd0, ready}, 128'd1);
    chk("rk_is_key", {127'd0, is_key}, 128'd1);
    chk("rk_sent", {112'd0, blocks_sent}, 128'd1);
    chk("rk_data", data_out, 128'hd0d1d2d3d4d5d6d7d8d9dadbdcdddedf);
    tick();
    complete = 1'b1;
    tick();
    complete = 1'b0;
    chk("rk_complete_on_key", {127'd0, proto_err}, 128'd1);

    // complete while idle after a fresh reset
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    chk("idle_perr_clear", {127'd0, proto_err}, 128'd0);
    complete = 1'b1;
    tick();
    complete = 1'b0;
    chk("idle_perr_set", {127'd0, proto_err}, 128'd1);
    chk("idle_no_ready", {127'd0, ready}, 128'd0);
    chk("idle_sent", {112'd0, blocks_sent}, 128'd0);
    repeat (3) tick();
    chk("idle_perr_sticky", {127'd0, proto_err}, 128'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
